// File: rtl/digitizer_pkg.sv
// Shared digitizer definitions used on both the TX (decompose) and RX
// (compose) sides so octet ordering is identical in both directions.
//
// Contents:
//   SAMPLE_W / OCTET_W / TAIL_W   sample, octet and tail-nibble widths
//   sample_t, octet_t             scalar types
//   sample_pair_t                 {s1, s0} pair as stored in the TX buffer
//   octet_pair_t                  {hi, lo} octets produced from one sample
//   split_sample()                sample + tail -> {sample[11:4]}, {sample[3:0], tail}
package digitizer_pkg;

  localparam int SAMPLE_W = 12;
  localparam int OCTET_W  = 8;
  localparam int TAIL_W   = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [OCTET_W-1:0]  octet_t;

  typedef struct packed {
    sample_t s1;
    sample_t s0;
  } sample_pair_t;

  typedef struct packed {
    octet_t hi;
    octet_t lo;
  } octet_pair_t;

  // High octet carries the top eight data bits; the low octet carries the
  // remaining data bits followed by the tail nibble.
  function automatic octet_pair_t split_sample(input sample_t           sample,
                                               input logic [TAIL_W-1:0] tail);
    octet_pair_t o;
    o.hi = sample[SAMPLE_W-1:SAMPLE_W-OCTET_W];
    o.lo = {sample[SAMPLE_W-OCTET_W-1:0], tail};
    return o;
  endfunction

endpackage

// File: rtl/sample_pair_fifo.sv
// First-word-fall-through circular buffer for sample pairs.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset (pointers/count only)
//   wr_en_i      in   write request; ignored while full
//   wr_data_i    in   WIDTH-bit entry to store
//   rd_en_i      in   pop request; ignored while empty
//   head_o       out  entry at the read pointer
//   head_next_o  out  entry one slot after the read pointer
//   count_o      out  number of stored entries, 0..DEPTH
//   full_o       out  count == DEPTH
//   empty_o      out  count == 0
module sample_pair_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         head_next_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count_q, count_d;
  logic             wr_fire, rd_fire;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign wr_fire     = wr_en_i & ~full_o;
  assign rd_fire     = rd_en_i & ~empty_o;
  assign rd_ptr_inc  = ptr_inc(rd_ptr_q);
  assign head_o      = mem_q[rd_ptr_q];
  // Lets the consumer preload the following entry on a pop without a bubble.
  assign head_next_o = mem_q[rd_ptr_inc];

  always_comb begin
    wr_ptr_d = wr_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_inc : rd_ptr_q;
    count_d  = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; stale contents are never exposed because the
  // count gates every use of the head.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/sample_decompose.sv
// TX-side sample splitter: buffers 12-bit sample pairs and presents each pair
// as four registered octets for the lane controller, popping one pair per
// Read strobe. A ramp source can replace the buffered data for loopback.
//
// Ports:
//   Clock                 in   clock, rising edge
//   Reset_N               in   asynchronous active-low reset
//   Input_Sample_0/1      in   12-bit samples of the incoming pair
//   Input_Valid           in   pair valid
//   Input_Ready           out  buffer can accept (transfer = Valid & Ready)
//   Pattern_Enable        in   1 = ramp pattern replaces buffered data
//   Output_MainData_0..3  out  octets: s0 hi, {s0 lo, tail}, s1 hi, {s1 lo, tail}
//   Output_MainData_Read  in   consume the pair currently on the octets
//   Empty                 out  no buffered pair
//   Underflow             out  sticky: Read while empty with pattern off
module sample_decompose
  import digitizer_pkg::*;
#(
  parameter int                FIFO_DEPTH = 8,
  parameter logic [TAIL_W-1:0] TAIL_BITS  = 4'h0
) (
  input  logic                Clock,
  input  logic                Reset_N,
  input  logic [SAMPLE_W-1:0] Input_Sample_0,
  input  logic [SAMPLE_W-1:0] Input_Sample_1,
  input  logic                Input_Valid,
  output logic                Input_Ready,
  input  logic                Pattern_Enable,
  output logic [OCTET_W-1:0]  Output_MainData_0,
  output logic [OCTET_W-1:0]  Output_MainData_1,
  output logic [OCTET_W-1:0]  Output_MainData_2,
  output logic [OCTET_W-1:0]  Output_MainData_3,
  input  logic                Output_MainData_Read,
  output logic                Empty,
  output logic                Underflow
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] TWO_CNT = CW'(2);

  sample_pair_t   wr_pair, head_pair, head_next_pair, pair_d;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full, fifo_empty;
  logic           wr_req, rd_req, rd_fire;
  sample_t        ramp_q, ramp_d;
  logic           pat_q;
  logic           underflow_q, underflow_d;
  octet_pair_t    sp0_d, sp1_d;
  octet_t         oct0_q, oct1_q, oct2_q, oct3_q;

  assign wr_pair.s0 = Input_Sample_0;
  assign wr_pair.s1 = Input_Sample_1;

  // Ready is forced low while reset is held so nothing is offered during it.
  assign Input_Ready = Reset_N & ~fifo_full;
  assign wr_req      = Input_Valid & Input_Ready;
  // In pattern mode the buffer is frozen: Reads only advance the ramp.
  assign rd_req      = Output_MainData_Read & ~Pattern_Enable;
  assign rd_fire     = rd_req & ~fifo_empty;

  sample_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(sample_pair_t))
  ) u_fifo (
    .clk_i       (Clock),
    .rst_ni      (Reset_N),
    .wr_en_i     (wr_req),
    .wr_data_i   (wr_pair),
    .rd_en_i     (rd_req),
    .head_o      (head_pair),
    .head_next_o (head_next_pair),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next octet contents. Without a Read the register shows the current head
  // (so a new head appears one cycle after it arrives). On a Read the
  // consumed pair is replaced by the following entry in the same edge; with
  // only one entry left the octets drop to idle zeros.
  always_comb begin
    ramp_d      = ramp_q;
    pair_d      = '0;
    underflow_d = underflow_q | (rd_req & fifo_empty);
    if (Pattern_Enable) begin
      if (!pat_q) begin
        ramp_d = '0;
      end else if (Output_MainData_Read) begin
        ramp_d = ramp_q + SAMPLE_W'(2);
      end
      pair_d.s0 = ramp_d;
      pair_d.s1 = ramp_d + SAMPLE_W'(1);
    end else if (rd_fire) begin
      if (fifo_count >= TWO_CNT) pair_d = head_next_pair;
    end else if (!fifo_empty) begin
      pair_d = head_pair;
    end
    sp0_d = split_sample(pair_d.s0, TAIL_BITS);
    sp1_d = split_sample(pair_d.s1, TAIL_BITS);
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      ramp_q      <= '0;
      pat_q       <= 1'b0;
      underflow_q <= 1'b0;
      oct0_q      <= '0;
      oct1_q      <= '0;
      oct2_q      <= '0;
      oct3_q      <= '0;
    end else begin
      ramp_q      <= ramp_d;
      pat_q       <= Pattern_Enable;
      underflow_q <= underflow_d;
      oct0_q      <= sp0_d.hi;
      oct1_q      <= sp0_d.lo;
      oct2_q      <= sp1_d.hi;
      oct3_q      <= sp1_d.lo;
    end
  end

  assign Output_MainData_0 = oct0_q;
  assign Output_MainData_1 = oct1_q;
  assign Output_MainData_2 = oct2_q;
  assign Output_MainData_3 = oct3_q;
  assign Empty             = fifo_empty;
  assign Underflow         = underflow_q;

endmodule

// File: tb/tb_sample_decompose.sv
module tb_sample_decompose;

  localparam int         DEPTH = 8;
  localparam logic [3:0] TAIL  = 4'h0;

  logic        Clock = 1'b0;
  logic        Reset_N;
  logic [11:0] Input_Sample_0, Input_Sample_1;
  logic        Input_Valid, Input_Ready;
  logic        Pattern_Enable;
  logic [7:0]  Output_MainData_0, Output_MainData_1, Output_MainData_2, Output_MainData_3;
  logic        Output_MainData_Read;
  logic        Empty, Underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] sb_q[$];   // expected pairs {s1, s0}, in order of acceptance
  int          mcnt = 0;  // expected buffer occupancy

  sample_decompose #(
    .FIFO_DEPTH (DEPTH),
    .TAIL_BITS  (TAIL)
  ) dut (
    .Clock                (Clock),
    .Reset_N              (Reset_N),
    .Input_Sample_0       (Input_Sample_0),
    .Input_Sample_1       (Input_Sample_1),
    .Input_Valid          (Input_Valid),
    .Input_Ready          (Input_Ready),
    .Pattern_Enable       (Pattern_Enable),
    .Output_MainData_0    (Output_MainData_0),
    .Output_MainData_1    (Output_MainData_1),
    .Output_MainData_2    (Output_MainData_2),
    .Output_MainData_3    (Output_MainData_3),
    .Output_MainData_Read (Output_MainData_Read),
    .Empty                (Empty),
    .Underflow            (Underflow)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] oct_exp(input logic [11:0] s0, input logic [11:0] s1);
    return {s0, TAIL, s1, TAIL};
  endfunction

  function automatic logic [31:0] octs();
    return {Output_MainData_0, Output_MainData_1, Output_MainData_2, Output_MainData_3};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic, entered and left at a falling edge. Outputs are
  // checked first, then inputs are driven for the coming rising edge.
  task automatic cyc(input bit v, input logic [11:0] s0, input logic [11:0] s1, input bit rd);
    logic [23:0] e;
    bit acc;
    acc = v && (mcnt != DEPTH);
    chk("empty", Empty, (mcnt == 0));
    if (v) chk("ready", Input_Ready, (mcnt != DEPTH));
    if (rd && mcnt != 0) begin
      e = sb_q.pop_front();
      mcnt--;
      chk("read_octets", octs(), oct_exp(e[11:0], e[23:12]));
    end
    Input_Valid          = v;
    Input_Sample_0       = s0;
    Input_Sample_1       = s1;
    Output_MainData_Read = rd;
    if (acc) begin
      sb_q.push_back({s1, s0});
      mcnt++;
    end
    @(negedge Clock);
    Input_Valid          = 1'b0;
    Output_MainData_Read = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 12'h000, 12'h000, 1'b0);
  endtask

  initial begin
    logic [11:0] r;
    Reset_N              = 1'b0;
    Input_Sample_0       = '0;
    Input_Sample_1       = '0;
    Input_Valid          = 1'b0;
    Pattern_Enable       = 1'b0;
    Output_MainData_Read = 1'b0;

    // Reset state while held
    #3;
    chk("rst_octets", octs(), 32'h0);
    chk("rst_empty", Empty, 1'b1);
    chk("rst_underflow", Underflow, 1'b0);
    chk("rst_ready", Input_Ready, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    Reset_N = 1'b1;
    #1;
    chk("rel_ready", Input_Ready, 1'b1);

    // Single pair, two-clock latency, octet layout and round trip
    cyc(1'b1, 12'hABC, 12'h123, 1'b0);
    chk("lat1_octets", octs(), 32'h0);
    idle();
    chk("lat2_octets", octs(), 32'hABC0_1230);
    chk("rt_s0", {Output_MainData_0, Output_MainData_1[7:4]}, 12'hABC);
    chk("rt_s1", {Output_MainData_2, Output_MainData_3[7:4]}, 12'h123);
    cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("after_last_octets", octs(), 32'h0);

    // Fill to full, refuse extra pairs, then drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 12'h100 + 12'(i), 12'h200 + 12'(i), 1'b0);
    chk("full_ready", Input_Ready, 1'b0);
    cyc(1'b1, 12'hEEE, 12'hDDD, 1'b0);
    cyc(1'b1, 12'h777, 12'h666, 1'b1);
    chk("full_rw_ready", Input_Ready, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("drained_octets", octs(), 32'h0);
    chk("drained_empty", Empty, 1'b1);

    // Continuous write+read across pointer wrap with occupancy held at 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'h3A0 + 12'(i), 12'h5C0 + 12'(i), 1'b0);
    idle();
    for (int i = 0; i < 100; i++)
      cyc(1'b1, 12'(i * 7 + 5), 12'(i * 13) ^ 12'hA5A, 1'b1);
    chk("stream_count", mcnt, 3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("stream_empty", Empty, 1'b1);

    // Read while empty sets a sticky underflow
    idle();
    chk("pre_underflow", Underflow, 1'b0);
    cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("underflow_set", Underflow, 1'b1);
    chk("underflow_octets", octs(), 32'h0);
    cyc(1'b1, 12'h0F0, 12'hF0F, 1'b0);
    idle();
    cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("underflow_held", Underflow, 1'b1);

    // Reset mid-stream discards buffered data
    cyc(1'b1, 12'h111, 12'h222, 1'b0);
    cyc(1'b1, 12'h333, 12'h444, 1'b0);
    idle();
    chk("pre_rst_octets", octs(), oct_exp(12'h111, 12'h222));
    #2;
    Reset_N = 1'b0;
    #1;
    chk("mid_rst_octets", octs(), 32'h0);
    chk("mid_rst_empty", Empty, 1'b1);
    chk("mid_rst_underflow", Underflow, 1'b0);
    chk("mid_rst_ready", Input_Ready, 1'b0);
    sb_q.delete();
    mcnt = 0;
    @(negedge Clock);
    Reset_N = 1'b1;
    #1;
    chk("mid_rel_ready", Input_Ready, 1'b1);
    cyc(1'b1, 12'h555, 12'h666, 1'b0);
    idle();
    cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("post_rst_empty", Empty, 1'b1);

    // Ramp pattern over a full 12-bit wrap, buffer left untouched
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'hC00 + 12'(i), 12'hD00 + 12'(i), 1'b0);
    idle();
    Pattern_Enable = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < 2050; i++) begin
      r = 12'(2 * i);
      chk("ramp", octs(), oct_exp(r, r + 12'd1));
      Output_MainData_Read = 1'b1;
      @(negedge Clock);
    end
    Output_MainData_Read = 1'b0;
    chk("ramp_end", octs(), oct_exp(12'h004, 12'h005));
    chk("ramp_underflow", Underflow, 1'b0);
    Pattern_Enable = 1'b0;
    @(negedge Clock);
    chk("pat_off_octets", octs(), oct_exp(12'hC00, 12'hD00));
    for (int i = 0; i < 3; i++) cyc(1'b0, 12'h0, 12'h0, 1'b1);
    chk("pat_fifo_empty", Empty, 1'b1);

    // Ramp restarts on re-enable; empty-buffer Reads in pattern mode are harmless
    Pattern_Enable = 1'b1;
    @(negedge Clock);
    chk("ramp_restart", octs(), oct_exp(12'h000, 12'h001));
    Output_MainData_Read = 1'b1;
    @(negedge Clock);
    Output_MainData_Read = 1'b0;
    chk("ramp_step", octs(), oct_exp(12'h002, 12'h003));
    chk("pat_no_underflow", Underflow, 1'b0);
    Pattern_Enable = 1'b0;
    @(negedge Clock);
    chk("idle_octets", octs(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
